// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, states,
// instruction classes and the datapath control encodings.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP,
    CLS_ADDU,
    CLS_SUBU,
    CLS_ORI,
    CLS_LUI,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_JAL,
    CLS_JR
  } instr_cls_e;

  localparam logic [1:0] MUX1_RT    = 2'b00;
  localparam logic [1:0] MUX1_RD    = 2'b01;
  localparam logic [1:0] MUX1_RA    = 2'b10;

  localparam logic [1:0] MUX3_ALU   = 2'b00;
  localparam logic [1:0] MUX3_DM    = 2'b01;
  localparam logic [1:0] MUX3_PC4   = 2'b10;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_OR     = 2'b10;

  localparam logic [1:0] EXT_ZERO   = 2'b00;
  localparam logic [1:0] EXT_SIGN   = 2'b01;
  localparam logic [1:0] EXT_LUI    = 2'b10;

  localparam logic [1:0] NPC_PC4    = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_IMEM    = 2'b10;
  localparam logic [1:0] ERR_DMEM    = 2'b11;

  // R-type results go to rd, immediate-form and load results go to rt
  function automatic logic [1:0] wbDest(input instr_cls_e cls);
    if (cls == CLS_NOP || cls == CLS_ADDU || cls == CLS_SUBU)
      return MUX1_RD;
    return MUX1_RT;
  endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational instruction classifier: maps the IR word to an instruction
// class and flags anything outside the supported subset as illegal.
module mips_mc_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  output instr_cls_e  cls_o,
  output logic        illegal_o
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];

  // Classify by opcode, then by funct for R-type; only the all-zero sll is accepted
  always_comb begin
    cls_o     = CLS_NOP;
    illegal_o = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls_o = CLS_ADDU;
          FN_SUBU: cls_o = CLS_SUBU;
          FN_JR:   cls_o = CLS_JR;
          FN_SLL:  illegal_o = (instr_i != 32'd0);
          default: illegal_o = 1'b1;
        endcase
      end
      OP_ORI:  cls_o = CLS_ORI;
      OP_LUI:  cls_o = CLS_LUI;
      OP_LW:   cls_o = CLS_LW;
      OP_SW:   cls_o = CLS_SW;
      OP_BEQ:  cls_o = CLS_BEQ;
      OP_JAL:  cls_o = CLS_JAL;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB, handles
// memory ready handshakes with a bounded wait, and traps into a sticky HALT.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        PCWE,
  output logic        IRWE,
  output logic        GRFWE,
  output logic        DMWE,
  output logic        DMRE,
  output logic [1:0]  MUX1,
  output logic        MUX2,
  output logic [1:0]  MUX3,
  output logic [1:0]  ALUOp,
  output logic [1:0]  EXTOp,
  output logic [1:0]  NPCOp,
  output logic        retire,
  output logic        halt,
  output logic [1:0]  err_code
);

  // The last wait cycle before a trap is the one where the counter holds MEM_TIMEOUT-1
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             halt_q;
  logic [1:0]       err_q;

  instr_cls_e       cls;
  logic             illegal;

  mips_mc_decode u_decode (
    .instr_i   (Instr),
    .cls_o     (cls),
    .illegal_o (illegal)
  );

  assign halt     = halt_q;
  assign err_code = err_q;

  // State sequencing, wait counting and sticky trap capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_FETCH;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      err_q   <= ERR_NONE;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (imem_ready) begin
            state_q <= ST_DECODE;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_HALT;
            halt_q  <= 1'b1;
            err_q   <= ERR_IMEM;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_DECODE: begin
          if (illegal) begin
            state_q <= ST_HALT;
            halt_q  <= 1'b1;
            err_q   <= ERR_ILLEGAL;
          end else if (cls == CLS_JAL || cls == CLS_JR) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (cls == CLS_BEQ) begin
            state_q <= ST_FETCH;
            cnt_q   <= '0;
          end else if (cls == CLS_LW || cls == CLS_SW) begin
            state_q <= ST_MEM;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_WB;
          end
        end
        ST_MEM: begin
          if (dmem_ready) begin
            if (cls == CLS_SW) begin
              state_q <= ST_FETCH;
              cnt_q   <= '0;
            end else begin
              state_q <= ST_WB;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_HALT;
            halt_q  <= 1'b1;
            err_q   <= ERR_DMEM;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_WB: begin
          state_q <= ST_FETCH;
          cnt_q   <= '0;
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q <= ST_FETCH;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Datapath controls decoded from the current state and the IR contents
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    PCWE     = 1'b0;
    IRWE     = 1'b0;
    GRFWE    = 1'b0;
    DMWE     = 1'b0;
    DMRE     = 1'b0;
    MUX1     = MUX1_RT;
    MUX2     = 1'b0;
    MUX3     = MUX3_ALU;
    ALUOp    = ALU_ADD;
    EXTOp    = EXT_ZERO;
    NPCOp    = NPC_PC4;
    retire   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          IRWE  = 1'b1;
          PCWE  = 1'b1;
          NPCOp = NPC_PC4;
        end
      end
      ST_DECODE: begin
        if (!illegal && cls == CLS_JAL) begin
          GRFWE  = 1'b1;
          MUX1   = MUX1_RA;
          MUX3   = MUX3_PC4;
          PCWE   = 1'b1;
          NPCOp  = NPC_JUMP;
          retire = 1'b1;
        end else if (!illegal && cls == CLS_JR) begin
          PCWE   = 1'b1;
          NPCOp  = NPC_JR;
          retire = 1'b1;
        end
      end
      ST_EXEC: begin
        case (cls)
          CLS_SUBU: ALUOp = ALU_SUB;
          CLS_ORI: begin
            ALUOp = ALU_OR;
            MUX2  = 1'b1;
            EXTOp = EXT_ZERO;
          end
          CLS_LUI: begin
            ALUOp = ALU_ADD;
            MUX2  = 1'b1;
            EXTOp = EXT_LUI;
          end
          CLS_LW, CLS_SW: begin
            ALUOp = ALU_ADD;
            MUX2  = 1'b1;
            EXTOp = EXT_SIGN;
          end
          CLS_BEQ: begin
            ALUOp  = ALU_SUB;
            PCWE   = Zero;
            NPCOp  = NPC_BRANCH;
            retire = 1'b1;
          end
          default: ALUOp = ALU_ADD;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        DMRE     = (cls == CLS_LW);
        DMWE     = (cls == CLS_SW);
        retire   = (cls == CLS_SW) && dmem_ready;
      end
      ST_WB: begin
        GRFWE  = 1'b1;
        retire = 1'b1;
        MUX1   = wbDest(cls);
        MUX3   = (cls == CLS_LW) ? MUX3_DM : MUX3_ALU;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

endmodule
